// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding and widths, default screen size and lives width.
// Used by the collision/lives controller, the top-level game FSM and the HUD.
package game_pkg;

  localparam int c_STATE_W        = 3;
  localparam int c_LIVES_W        = 3;
  localparam int c_DEFAULT_WIDTH  = 640;
  localparam int c_DEFAULT_HEIGHT = 480;

  typedef enum logic [c_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_GRACE = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } game_state_t;

endpackage

// File: rtl/frame_tick.sv
// Row-wrap edge detector: one-cycle strobe on the first clock where the row counter
// wraps from the last visible row back to 0, however long the divided counter holds.
module frame_tick #(
  parameter int c_GAME_HEIGHT = 480
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [9:0] i_Row_Count_Div,
  output logic       o_Frame_Tick
);

  logic [9:0] r_Prev_Row;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_Prev_Row <= '0;
    else          r_Prev_Row <= i_Row_Count_Div;
  end

  assign o_Frame_Tick = (r_Prev_Row == 10'(c_GAME_HEIGHT - 1)) && (i_Row_Count_Div == 10'd0);

endmodule

// File: rtl/collision_ctrl.sv
// Frame-level frog/car collision latch and lives FSM for the road-crossing game.
// Define COLLISION_GRACE_EN to enable the post-hit invulnerability (GRACE) state.
module collision_ctrl
  import game_pkg::*;
#(
  parameter int c_GAME_WIDTH   = 640,
  parameter int c_GAME_HEIGHT  = 480,
  parameter int c_NUM_CARS     = 4,
  parameter int c_LIVES        = 3,
  parameter int c_GRACE_FRAMES = 60,
  parameter int c_GOAL_ROW     = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Game_Active,
  input  logic [9:0]            i_Col_Count_Div,
  input  logic [9:0]            i_Row_Count_Div,
  input  logic [c_NUM_CARS-1:0] i_Draw_Cars,
  input  logic                  i_Draw_Frog,
  input  logic [9:0]            i_Frog_Y,
  output logic                  o_Hit_Pulse,
  output logic                  o_Respawn,
  output logic [c_LIVES_W-1:0]  o_Lives,
  output logic                  o_Game_Over,
  output logic                  o_Win,
  output logic [c_STATE_W-1:0]  o_State
);

  localparam logic [c_LIVES_W-1:0] c_LIVES_INIT = c_LIVES_W'(c_LIVES);

  game_state_t          r_State, w_State_Next;
  logic [c_LIVES_W-1:0] r_Lives, w_Lives_Next;
  logic [7:0]           r_Grace_Cnt, w_Grace_Next;
  logic                 r_Hit_Frame, w_Hit_Frame_Next;
  logic                 r_Hit_Pulse, w_Hit_Accept;
  logic                 w_Frame_Tick, w_Overlap;

  frame_tick #(.c_GAME_HEIGHT(c_GAME_HEIGHT)) u_frame_tick (
    .i_Clk           (i_Clk),
    .i_Rst_n         (i_Rst_n),
    .i_Row_Count_Div (i_Row_Count_Div),
    .o_Frame_Tick    (w_Frame_Tick)
  );

  assign w_Overlap = i_Draw_Frog && (|i_Draw_Cars) &&
                     (i_Col_Count_Div < 10'(c_GAME_WIDTH)) &&
                     (i_Row_Count_Div < 10'(c_GAME_HEIGHT));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State     <= ST_IDLE;
      r_Lives     <= c_LIVES_INIT;
      r_Grace_Cnt <= '0;
      r_Hit_Frame <= 1'b0;
      r_Hit_Pulse <= 1'b0;
    end else begin
      r_State     <= w_State_Next;
      r_Lives     <= w_Lives_Next;
      r_Grace_Cnt <= w_Grace_Next;
      r_Hit_Frame <= w_Hit_Frame_Next;
      r_Hit_Pulse <= w_Hit_Accept;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_State_Next = r_State;
    w_Lives_Next = r_Lives;
    w_Grace_Next = r_Grace_Cnt;
    w_Hit_Accept = 1'b0;
    if (!i_Game_Active) begin
      w_State_Next = ST_IDLE;
      w_Lives_Next = c_LIVES_INIT;
      w_Grace_Next = '0;
    end else begin
      unique case (r_State)
        ST_IDLE: begin
          w_State_Next = ST_PLAY;
          w_Lives_Next = c_LIVES_INIT;
        end
        ST_PLAY: begin
          if (w_Frame_Tick) begin
            if (r_Hit_Frame) begin
              w_Hit_Accept = 1'b1;
              w_Lives_Next = (r_Lives != '0) ? r_Lives - c_LIVES_W'(1) : '0;
              w_Grace_Next = 8'(c_GRACE_FRAMES);
              if (r_Lives <= c_LIVES_W'(1)) begin
                w_State_Next = ST_OVER;
              end else begin
`ifdef COLLISION_GRACE_EN
                w_State_Next = ST_GRACE;
`else
                w_State_Next = ST_PLAY;
`endif
              end
            end else if (i_Frog_Y <= 10'(c_GOAL_ROW)) begin
              w_State_Next = ST_WIN;
            end
          end
        end
        ST_GRACE: begin
          if (w_Frame_Tick) begin
            w_Grace_Next = (r_Grace_Cnt != 8'd0) ? r_Grace_Cnt - 8'd1 : 8'd0;
            if (r_Grace_Cnt <= 8'd1) w_State_Next = ST_PLAY;
          end
        end
        ST_OVER: w_Lives_Next = '0;
        ST_WIN:  w_State_Next = ST_WIN;
        default: w_State_Next = ST_IDLE;
      endcase
    end
  end

  // Only PLAY frames collect overlaps; the tick cycle's own overlap opens the new frame.
  always_comb begin
    if (w_State_Next != ST_PLAY) w_Hit_Frame_Next = 1'b0;
    else if (w_Frame_Tick)       w_Hit_Frame_Next = w_Overlap;
    else                         w_Hit_Frame_Next = r_Hit_Frame | w_Overlap;
  end

  always_comb begin
    o_State     = r_State;
    o_Game_Over = (r_State == ST_OVER);
    o_Win       = (r_State == ST_WIN);
    o_Lives     = (r_State == ST_OVER) ? '0 : r_Lives;
    o_Hit_Pulse = r_Hit_Pulse;
    o_Respawn   = r_Hit_Pulse;
  end

endmodule

// File: tb/tb_collision_ctrl.sv
// Self-checking bench for collision_ctrl: directed scenarios plus randomized frames,
// compared cycle by cycle against a frame-rule reference model.
module tb_collision_ctrl;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int COLS  = 10;
  localparam int HOLD  = 2;
  localparam int NC    = 4;
  localparam int LIVES = 3;
  localparam int GRACE = 2;
  localparam int GOAL  = 0;
`ifdef COLLISION_GRACE_EN
  localparam bit GRACE_ON = 1'b1;
`else
  localparam bit GRACE_ON = 1'b0;
`endif
  localparam int S_IDLE = 0, S_PLAY = 1, S_GRACE = 2, S_OVER = 3, S_WIN = 4;

  logic          i_Clk = 1'b0;
  logic          i_Rst_n;
  logic          i_Game_Active;
  logic [9:0]    i_Col_Count_Div, i_Row_Count_Div, i_Frog_Y;
  logic [NC-1:0] i_Draw_Cars;
  logic          i_Draw_Frog;
  logic          o_Hit_Pulse, o_Respawn, o_Game_Over, o_Win;
  logic [2:0]    o_Lives, o_State;

  collision_ctrl #(
    .c_GAME_WIDTH(W), .c_GAME_HEIGHT(H), .c_NUM_CARS(NC),
    .c_LIVES(LIVES), .c_GRACE_FRAMES(GRACE), .c_GOAL_ROW(GOAL)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Game_Active(i_Game_Active),
    .i_Col_Count_Div(i_Col_Count_Div), .i_Row_Count_Div(i_Row_Count_Div),
    .i_Draw_Cars(i_Draw_Cars), .i_Draw_Frog(i_Draw_Frog), .i_Frog_Y(i_Frog_Y),
    .o_Hit_Pulse(o_Hit_Pulse), .o_Respawn(o_Respawn), .o_Lives(o_Lives),
    .o_Game_Over(o_Game_Over), .o_Win(o_Win), .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: game state as plain integers, updated once per clock.
  int m_st, m_lives, m_grace, m_prev_row, m_ticks;
  bit m_frame_hit, m_pulse;
  int hit_ticks[$];
  int hit_lives[$];
  int hit_state[$];

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_lives = LIVES; m_grace = 0;
    m_prev_row = 0; m_frame_hit = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit act, input int col, input int row,
                            input int cars, input bit frog, input int fy);
    bit tick, ov;
    tick = (m_prev_row == H - 1) && (row == 0);
    ov   = frog && (cars != 0) && (col < W) && (row < H);
    if (tick) m_ticks++;
    m_pulse = 1'b0;
    if (!act) begin
      m_st = S_IDLE; m_lives = LIVES; m_grace = 0;
    end else begin
      case (m_st)
        S_IDLE: m_st = S_PLAY;
        S_PLAY: if (tick) begin
          if (m_frame_hit) begin
            m_pulse = 1'b1;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            if (m_lives == 0) m_st = S_OVER;
            else if (GRACE_ON) begin m_st = S_GRACE; m_grace = GRACE; end
          end else if (fy <= GOAL) begin
            m_st = S_WIN;
          end
        end
        S_GRACE: if (tick) begin
          m_grace--;
          if (m_grace <= 0) m_st = S_PLAY;
        end
        default: ;
      endcase
    end
    if (m_st != S_PLAY) m_frame_hit = 1'b0;
    else if (tick)      m_frame_hit = ov;
    else                m_frame_hit = m_frame_hit | ov;
    m_prev_row = row;
  endtask

  task automatic drive_cycle(input bit act, input int col, input int row,
                             input int cars, input bit frog, input int fy);
    i_Game_Active   = act;
    i_Col_Count_Div = 10'(col);
    i_Row_Count_Div = 10'(row);
    i_Draw_Cars     = NC'(cars);
    i_Draw_Frog     = frog;
    i_Frog_Y        = 10'(fy);
    @(posedge i_Clk); #1;
    model_step(act, col, row, cars, frog, fy);
    check("state",     o_State,     m_st);
    check("lives",     o_Lives,     m_lives);
    check("hit_pulse", o_Hit_Pulse, m_pulse);
    check("respawn",   o_Respawn,   m_pulse);
    check("game_over", o_Game_Over, (m_st == S_OVER));
    check("win",       o_Win,       (m_st == S_WIN));
    if (o_Hit_Pulse === 1'b1) begin
      hit_ticks.push_back(m_ticks);
      hit_lives.push_back(int'(o_Lives));
      hit_state.push_back(int'(o_State));
    end
    if (errors > 40) begin
      $display("FAIL abort: error limit reached");
      finish_sim();
    end
  endtask

  // mode 0: no frog; 1: random frog/cars; 2: one overlap on car 2 at (3,2);
  // 3: frog and cars together only in the hidden columns.
  task automatic run_frame(input int mode, input int fy_tick, input int fy,
                           input int drop_at, input int stop_at);
    int  idx, cars;
    bit  frog, act;
    idx = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cars = int'($urandom_range(0, 15));
        frog = 1'b0;
        case (mode)
          1: begin
            cars = int'($urandom_range(0, 15) & $urandom_range(0, 15));
            frog = ($urandom_range(0, 4) == 0);
          end
          2: if (c == 3 && r == 2) begin cars = 4; frog = 1'b1; end
          3: begin frog = (c >= W); if (c < W) cars = 0; end
          default: ;
        endcase
        for (int h = 0; h < HOLD; h++) begin
          if (stop_at >= 0 && idx >= stop_at) return;
          act = !(drop_at >= 0 && idx >= drop_at && idx < drop_at + 3);
          drive_cycle(act, c, r, cars, frog, (idx == 0) ? fy_tick : fy);
          idx++;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},   o_State,     S_IDLE);
    check({tag, "_lives"},   o_Lives,     LIVES);
    check({tag, "_hit"},     o_Hit_Pulse, 0);
    check({tag, "_respawn"}, o_Respawn,   0);
    check({tag, "_over"},    o_Game_Over, 0);
    check({tag, "_win"},     o_Win,       0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit expired");
    finish_sim();
  end

  initial begin
    int n;
    m_ticks = 0;
    model_reset();
    i_Game_Active = 1'b0; i_Col_Count_Div = '0; i_Row_Count_Div = '0;
    i_Draw_Cars = '0; i_Draw_Frog = 1'b0; i_Frog_Y = 10'd5;
    i_Rst_n = 1'b1;
    #2 i_Rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge i_Clk); @(posedge i_Clk); #1 i_Rst_n = 1'b1;

    // Idle-to-play with no overlap, then overlaps hidden in the blanking columns.
    for (int f = 0; f < 3; f++) run_frame(0, 5, 5, -1, -1);
    check("play_after_3", o_State, S_PLAY);
    check("lives_after_3", o_Lives, LIVES);
    for (int f = 0; f < 2; f++) run_frame(3, 5, 5, -1, -1);
    check("no_hidden_hit", hit_ticks.size(), 0);

    // Single overlap pixel on car 2, repeated every frame until the second hit.
    n = 0;
    while (hit_ticks.size() < 2 && n < 8) begin run_frame(2, 5, 5, -1, -1); n++; end
    check("two_hits_seen", hit_ticks.size(), 2);
    if (hit_ticks.size() >= 2) begin
      check("hit1_lives", hit_lives[0], LIVES - 1);
      check("hit1_state", hit_state[0], GRACE_ON ? S_GRACE : S_PLAY);
      check("hit_spacing", hit_ticks[1] - hit_ticks[0], GRACE_ON ? GRACE + 1 : 1);
      check("hit2_lives", hit_lives[1], LIVES - 2);
    end

    // Third hit ends the game; dropping active returns to IDLE with full lives.
    n = 0;
    while (hit_ticks.size() < 3 && n < 8) begin run_frame(2, 5, 5, -1, -1); n++; end
    run_frame(0, 5, 5, -1, -1);
    check("over_flag", o_Game_Over, 1);
    check("over_lives", o_Lives, 0);
    check("over_state", o_State, S_OVER);
    drive_cycle(1'b0, 0, 1, 0, 1'b0, 5);
    check("idle_after_drop", o_State, S_IDLE);
    check("idle_lives", o_Lives, LIVES);

    // Goal row reached in a frame with overlap: hit wins over win.
    run_frame(0, 5, 5, -1, -1);
    run_frame(2, 5, 0, -1, -1);
    run_frame(0, 0, 5, -1, -1);
    check("hit_over_win_cnt", hit_ticks.size(), 4);
    check("hit_over_win_flag", o_Win, 0);
    if (hit_lives.size() >= 4) check("hit_over_win_lives", hit_lives[3], LIVES - 1);
    run_frame(0, 5, 5, -1, -1);
    run_frame(0, 5, 5, -1, -1);
    run_frame(0, 5, 0, -1, -1);
    run_frame(0, 0, 5, -1, -1);
    check("win_flag", o_Win, 1);
    check("win_state", o_State, S_WIN);

    // Randomized frames with occasional game-active drops.
    for (int f = 0; f < 100; f++) begin
      int fy;
      fy = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9));
      run_frame(int'($urandom_range(0, 2)), fy, fy,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 100)) : -1, -1);
    end

    // Asynchronous reset mid-frame after an overlap has been latched.
    drive_cycle(1'b0, 0, 1, 0, 1'b0, 5);
    run_frame(0, 5, 5, -1, -1);
    run_frame(2, 5, 5, -1, 70);
    n = hit_ticks.size();
    #2 i_Rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(posedge i_Clk); @(posedge i_Clk); #1 i_Rst_n = 1'b1;
    model_reset();
    run_frame(0, 5, 5, -1, -1);
    run_frame(0, 5, 5, -1, -1);
    check("no_pulse_after_reset", hit_ticks.size(), n);
    check("play_after_reset", o_State, S_PLAY);

    finish_sim();
  end

endmodule
